// File: rtl/split_radio_pkg.sv
// Shared types and default constants for the split-radio power sequencer.
package split_radio_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_POWER_UP   = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RAMP       = 3'd3,
    ST_READY      = 3'd4,
    ST_FAULT_WAIT = 3'd5,
    ST_LOCKOUT    = 3'd6
  } state_t;

  localparam int DEF_NUM_BRANCHES  = 4;
  localparam int DEF_SETTLE_CYCLES = 1000;
  localparam int DEF_BRANCH_STEP   = 250;
  localparam int DEF_PGOOD_TIMEOUT = 10000;
  localparam int DEF_MAX_RETRIES   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/split_radio_pgood_sync.sv
// Two-flop synchroniser for the asynchronous power-good input from the LNA supply.
module split_radio_pgood_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/split_radio_power_seq.sv
// Power sequencer for a split-radio chain: LNA supply, settle, branch ramp, fault retry/lockout.
// Define SPLIT_RADIO_STAGGER_EN to stagger branch enables BRANCH_STEP clocks apart.
module split_radio_power_seq
  import split_radio_pkg::*;
#(
  parameter int NUM_BRANCHES  = DEF_NUM_BRANCHES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int BRANCH_STEP   = DEF_BRANCH_STEP,
  parameter int PGOOD_TIMEOUT = DEF_PGOOD_TIMEOUT,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                               Clock100Mhz,
  input  logic                               ResetN,
  input  logic                               Enable,
  input  logic                               ToSplitRadio,
  output logic                               LnaEnable,
  output logic [NUM_BRANCHES-1:0]            BranchEnable,
  output logic                               Ready,
  output logic                               Fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   RetryCount,
  output logic [STATE_W-1:0]                 State
);

  localparam int RC_W  = $clog2(MAX_RETRIES + 1);
  localparam int TMR_W = $clog2(max3(SETTLE_CYCLES, BRANCH_STEP, PGOOD_TIMEOUT) + 1);

  typedef logic [TMR_W-1:0] tmr_t;
  typedef logic [NUM_BRANCHES-1:0] br_t;

  localparam tmr_t TO_LAST     = tmr_t'(PGOOD_TIMEOUT - 1);
  localparam tmr_t SETTLE_LAST = tmr_t'(SETTLE_CYCLES - 1);
  localparam tmr_t TMR_MAX     = '1;
  localparam br_t  BR_ALL      = '1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRIES);
`ifdef SPLIT_RADIO_STAGGER_EN
  localparam tmr_t STEP_LAST   = tmr_t'(BRANCH_STEP - 1);
  localparam br_t  BR_FIRST    = br_t'(1);
`else
  localparam br_t  BR_FIRST    = BR_ALL;
`endif

  logic pgood_s;

  split_radio_pgood_sync u_pgood_sync (
    .clk      (Clock100Mhz),
    .rst_n    (ResetN),
    .async_in (ToSplitRadio),
    .sync_out (pgood_s)
  );

  state_t            state_q,  state_d;
  tmr_t              timer_q,  timer_d;
  br_t               branch_q, branch_d;
  logic [RC_W-1:0]   retry_q,  retry_d;
  logic              lna_q,    lna_d;
  logic              ready_q,  ready_d;
  logic              fault_q,  fault_d;
  logic              fault_go;
  tmr_t              timer_inc;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    branch_d  = branch_q;
    retry_d   = retry_q;
    fault_go  = 1'b0;
    timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + tmr_t'(1);

    // Dropping Enable wins over everything, including a power-good loss.
    if (!Enable) begin
      state_d  = ST_IDLE;
      timer_d  = '0;
      branch_d = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_POWER_UP;
          timer_d = '0;
        end
        ST_POWER_UP: begin
          if (pgood_s) begin
            state_d = ST_SETTLE;
            timer_d = '0;
          end else if (timer_q >= TO_LAST) begin
            fault_go = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_SETTLE: begin
          if (!pgood_s) begin
            fault_go = 1'b1;
          end else if (timer_q >= SETTLE_LAST) begin
            state_d  = ST_RAMP;
            timer_d  = '0;
            branch_d = BR_FIRST;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_RAMP: begin
          if (!pgood_s) begin
            fault_go = 1'b1;
          end else if (&branch_q) begin
            state_d = ST_READY;
            retry_d = '0;
          end
`ifdef SPLIT_RADIO_STAGGER_EN
          else if (timer_q >= STEP_LAST) begin
            branch_d = (branch_q << 1) | br_t'(1);
            timer_d  = '0;
          end else begin
            timer_d = timer_inc;
          end
`endif
        end
        ST_READY: begin
          if (!pgood_s) fault_go = 1'b1;
        end
        ST_FAULT_WAIT: begin
          if (retry_q >= RC_MAX) begin
            state_d = ST_LOCKOUT;
          end else if (timer_q >= SETTLE_LAST) begin
            state_d = ST_POWER_UP;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_LOCKOUT: begin
          state_d = ST_LOCKOUT;
        end
        default: begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          branch_d = '0;
          retry_d  = '0;
        end
      endcase

      if (fault_go) begin
        state_d  = ST_FAULT_WAIT;
        timer_d  = '0;
        branch_d = '0;
        retry_d  = (retry_q >= RC_MAX) ? RC_MAX : retry_q + RC_W'(1);
      end
    end

    // Outputs are decoded from the next state so they register with it.
    lna_d   = (state_d == ST_POWER_UP) || (state_d == ST_SETTLE) ||
              (state_d == ST_RAMP)     || (state_d == ST_READY);
    ready_d = (state_d == ST_READY);
    fault_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      branch_q <= '0;
      retry_q  <= '0;
      lna_q    <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      branch_q <= branch_d;
      retry_q  <= retry_d;
      lna_q    <= lna_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign LnaEnable    = lna_q;
  assign BranchEnable = branch_q;
  assign Ready        = ready_q;
  assign Fault        = fault_q;
  assign RetryCount   = retry_q;
  assign State        = state_q;

endmodule

// File: tb/tb_split_radio_power_seq.sv
// Bench for split_radio_power_seq: directed vector table, reset corner case, random run vs. reference model.
module tb_split_radio_power_seq;
  import split_radio_pkg::*;

  localparam int NB = 4;
  localparam int SC = 8;
  localparam int BS = 4;
  localparam int PT = 32;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          pg;
  logic          lna;
  logic [NB-1:0] br;
  logic          rdy;
  logic          flt;
  logic [1:0]    rc;
  logic [2:0]    st;

  always #5 clk = ~clk;

  split_radio_power_seq #(
    .NUM_BRANCHES  (NB),
    .SETTLE_CYCLES (SC),
    .BRANCH_STEP   (BS),
    .PGOOD_TIMEOUT (PT),
    .MAX_RETRIES   (MR)
  ) dut (
    .Clock100Mhz  (clk),
    .ResetN       (rst_n),
    .Enable       (en),
    .ToSplitRadio (pg),
    .LnaEnable    (lna),
    .BranchEnable (br),
    .Ready        (rdy),
    .Fault        (flt),
    .RetryCount   (rc),
    .State        (st)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase plus cycles spent in it, synchroniser as a 2-deep delay.
  state_t m_st;
  int     m_t;
  int     m_retry;
  logic   m_s1, m_s2;

`ifdef SPLIT_RADIO_STAGGER_EN
  localparam int RAMP_LEN = (NB - 1) * BS + 1;
`else
  localparam int RAMP_LEN = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_t = 0; m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic m_enter(input state_t s);
    m_st = s;
    m_t  = 1;
    if (s == ST_FAULT_WAIT) m_retry = (m_retry + 1 > MR) ? MR : m_retry + 1;
    if (s == ST_READY || s == ST_IDLE) m_retry = 0;
  endtask

  task automatic model_step(input logic e, input logic p);
    logic ps;
    ps = m_s2; m_s2 = m_s1; m_s1 = p;
    if (!e) begin
      m_st = ST_IDLE; m_t = 0; m_retry = 0;
      return;
    end
    case (m_st)
      ST_IDLE:       m_enter(ST_POWER_UP);
      ST_POWER_UP:   if (ps) m_enter(ST_SETTLE);
                     else if (m_t >= PT) m_enter(ST_FAULT_WAIT);
                     else m_t++;
      ST_SETTLE:     if (!ps) m_enter(ST_FAULT_WAIT);
                     else if (m_t >= SC) m_enter(ST_RAMP);
                     else m_t++;
      ST_RAMP:       if (!ps) m_enter(ST_FAULT_WAIT);
                     else if (m_t >= RAMP_LEN) m_enter(ST_READY);
                     else m_t++;
      ST_READY:      if (!ps) m_enter(ST_FAULT_WAIT);
      ST_FAULT_WAIT: if (m_retry >= MR) m_enter(ST_LOCKOUT);
                     else if (m_t >= SC) m_enter(ST_POWER_UP);
                     else m_t++;
      default:       ;
    endcase
  endtask

  function automatic logic [NB-1:0] model_br();
    int k;
    if (m_st == ST_READY) return '1;
    if (m_st != ST_RAMP) return '0;
`ifdef SPLIT_RADIO_STAGGER_EN
    k = 1 + (m_t - 1) / BS;
    if (k > NB) k = NB;
`else
    k = NB;
`endif
    return NB'((1 << k) - 1);
  endfunction

  task automatic check_model(input string tag);
    logic exp_lna;
    exp_lna = (m_st == ST_POWER_UP) || (m_st == ST_SETTLE) ||
              (m_st == ST_RAMP) || (m_st == ST_READY);
    chk({tag, "_state"}, 32'(st),  32'(m_st));
    chk({tag, "_lna"},   32'(lna), 32'(exp_lna));
    chk({tag, "_br"},    32'(br),  32'(model_br()));
    chk({tag, "_ready"}, 32'(rdy), 32'(m_st == ST_READY));
    chk({tag, "_fault"}, 32'(flt), 32'(m_st == ST_LOCKOUT));
    chk({tag, "_retry"}, 32'(rc),  32'(m_retry));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_step(en, pg);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic          en;
    logic          pg;
    int            n;
    state_t        st;
    logic          lna;
    logic [NB-1:0] br;
    logic          rdy;
    logic          flt;
    logic [1:0]    rc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic p, input int n, input state_t s, input logic l,
                     input logic [NB-1:0] b, input logic r, input logic f, input logic [1:0] c);
    vec_t v;
    v.en = e; v.pg = p; v.n = n; v.st = s; v.lna = l; v.br = b; v.rdy = r; v.flt = f; v.rc = c;
    vecs.push_back(v);
  endtask

  initial begin
    // Nominal power-up
    add(1, 0, 1, ST_POWER_UP,   1, 4'b0000, 0, 0, 0);
    add(1, 1, 2, ST_POWER_UP,   1, 4'b0000, 0, 0, 0);
    add(1, 1, 1, ST_SETTLE,     1, 4'b0000, 0, 0, 0);
    add(1, 1, 7, ST_SETTLE,     1, 4'b0000, 0, 0, 0);
`ifdef SPLIT_RADIO_STAGGER_EN
    add(1, 1, 1, ST_RAMP,       1, 4'b0001, 0, 0, 0);
    add(1, 1, 3, ST_RAMP,       1, 4'b0001, 0, 0, 0);
    add(1, 1, 1, ST_RAMP,       1, 4'b0011, 0, 0, 0);
    add(1, 1, 3, ST_RAMP,       1, 4'b0011, 0, 0, 0);
    add(1, 1, 1, ST_RAMP,       1, 4'b0111, 0, 0, 0);
    add(1, 1, 3, ST_RAMP,       1, 4'b0111, 0, 0, 0);
    add(1, 1, 1, ST_RAMP,       1, 4'b1111, 0, 0, 0);
`else
    add(1, 1, 1, ST_RAMP,       1, 4'b1111, 0, 0, 0);
`endif
    add(1, 1, 1, ST_READY,      1, 4'b1111, 1, 0, 0);
    // One-clock brownout
    add(1, 0, 1, ST_READY,      1, 4'b1111, 1, 0, 0);
    add(1, 1, 1, ST_READY,      1, 4'b1111, 1, 0, 0);
    add(1, 1, 1, ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 1);
    add(1, 1, 7, ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 1);
    add(1, 1, 1, ST_POWER_UP,   1, 4'b0000, 0, 0, 1);
    add(1, 1, 1, ST_SETTLE,     1, 4'b0000, 0, 0, 1);
    add(0, 0, 2, ST_IDLE,       0, 4'b0000, 0, 0, 0);
    // Repeated power-good timeouts into lockout
    add(1, 0, 1,  ST_POWER_UP,   1, 4'b0000, 0, 0, 0);
    add(1, 0, 31, ST_POWER_UP,   1, 4'b0000, 0, 0, 0);
    add(1, 0, 1,  ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 1);
    add(1, 0, 7,  ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 1);
    add(1, 0, 1,  ST_POWER_UP,   1, 4'b0000, 0, 0, 1);
    add(1, 0, 31, ST_POWER_UP,   1, 4'b0000, 0, 0, 1);
    add(1, 0, 1,  ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 2);
    add(1, 0, 7,  ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 2);
    add(1, 0, 1,  ST_POWER_UP,   1, 4'b0000, 0, 0, 2);
    add(1, 0, 31, ST_POWER_UP,   1, 4'b0000, 0, 0, 2);
    add(1, 0, 1,  ST_FAULT_WAIT, 0, 4'b0000, 0, 0, 3);
    add(1, 0, 1,  ST_LOCKOUT,    0, 4'b0000, 0, 1, 3);
    add(1, 0, 5,  ST_LOCKOUT,    0, 4'b0000, 0, 1, 3);
    add(0, 0, 1,  ST_IDLE,       0, 4'b0000, 0, 0, 0);

    // Reset state
    rst_n = 1'b0; en = 1'b0; pg = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_model("reset");
    chk("reset_state", 32'(st), 32'(ST_IDLE));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en;
      pg = vecs[i].pg;
      repeat (vecs[i].n) cycle("vec_model");
      chk($sformatf("vec%0d_state", i), 32'(st),  32'(vecs[i].st));
      chk($sformatf("vec%0d_lna", i),   32'(lna), 32'(vecs[i].lna));
      chk($sformatf("vec%0d_br", i),    32'(br),  32'(vecs[i].br));
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].flt));
      chk($sformatf("vec%0d_retry", i), 32'(rc),  32'(vecs[i].rc));
    end

    // Asynchronous reset in the middle of the branch ramp
    en = 1'b1; pg = 1'b1;
`ifdef SPLIT_RADIO_STAGGER_EN
    repeat (17) cycle("ramp_model");
    chk("pre_reset_br", 32'(br), 32'(4'b0011));
`else
    repeat (12) cycle("ramp_model");
    chk("pre_reset_br", 32'(br), 32'(4'b1111));
`endif
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_state", 32'(st),  32'(ST_IDLE));
    chk("async_reset_lna",   32'(lna), 32'(0));
    chk("async_reset_br",    32'(br),  32'(0));
    chk("async_reset_ready", 32'(rdy), 32'(0));
    chk("async_reset_fault", 32'(flt), 32'(0));
    chk("async_reset_retry", 32'(rc),  32'(0));
    repeat (2) cycle("in_reset");
    rst_n = 1'b1;
    cycle("post_reset");
    chk("post_reset_state", 32'(st),  32'(ST_POWER_UP));
    chk("post_reset_lna",   32'(lna), 32'(1));

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rand_reset");
      end
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if (pg) pg = ($urandom_range(0, 149) != 0);
      else    pg = ($urandom_range(0, 24) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/split_radio_power_seq.md
SPLIT_RADIO_POWER_SEQ -- requirements
Module: split_radio_power_seq

Interface
REQ-001 SHALL have parameter NUM_BRANCHES, default 4, number of split-radio branch enables.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, post-power-good settle time and fault backoff time in clocks.
REQ-003 SHALL have parameter BRANCH_STEP, default 250, clocks between successive branch enables.
REQ-004 SHALL have parameter PGOOD_TIMEOUT, default 10000, max clocks in POWER_UP waiting for power-good.
REQ-005 SHALL have parameter MAX_RETRIES, default 3, faults tolerated before lockout.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port Clock100Mhz  in  1  sole clock, rising edge.
REQ-008 SHALL have port ResetN  in  1  asynchronous active-low reset.
REQ-009 SHALL have port Enable  in  1  synchronous request to power the radio chain.
REQ-010 SHALL have port ToSplitRadio  in  1  asynchronous power-good from the LNA supply stage.
REQ-011 SHALL have port LnaEnable  out  1  LNA supply enable.
REQ-012 SHALL have port BranchEnable  out  NUM_BRANCHES  per-branch enables.
REQ-013 SHALL have port Ready  out  1  chain fully powered.
REQ-014 SHALL have port Fault  out  1  lockout indicator.
REQ-015 SHALL have port RetryCount  out  $clog2(MAX_RETRIES+1)  faults since last clear.
REQ-016 SHALL have port State  out  3  current FSM state encoding.

Function
REQ-017 SHALL synchronise ToSplitRadio through two flops; pgood_s lags the input by 2 clocks.
REQ-018 SHALL implement states IDLE, POWER_UP, SETTLE, RAMP, READY, FAULT_WAIT, LOCKOUT.
REQ-019 IDLE: all outputs 0; Enable=1 -> POWER_UP, timer cleared.
REQ-020 POWER_UP: LnaEnable=1; pgood_s=1 -> SETTLE; timer reaches PGOOD_TIMEOUT-1 with pgood_s=0 -> FAULT_WAIT.
REQ-021 SETTLE: LnaEnable=1; after SETTLE_CYCLES clocks -> RAMP; pgood_s=0 at any cycle -> FAULT_WAIT.
REQ-022 RAMP: set BranchEnable[0] on entry, then the next bit (LSB first) every BRANCH_STEP clocks; one cycle after the last bit is set -> READY; pgood_s=0 -> FAULT_WAIT.
REQ-023 READY: Ready=1, all enables 1, RetryCount cleared on entry; pgood_s=0 -> FAULT_WAIT.
REQ-024 FAULT_WAIT: LnaEnable and BranchEnable 0 in the entry cycle; RetryCount increments on entry; if it reaches MAX_RETRIES -> LOCKOUT, else after SETTLE_CYCLES -> POWER_UP.
REQ-025 LOCKOUT: Fault=1, all enables 0; only exit is Enable=0.
REQ-026 Enable=0 in any state -> IDLE next clock, all enables 0, RetryCount cleared; it takes priority over pgood_s loss.
REQ-027 Timers SHALL saturate, never wrap; RetryCount SHALL saturate at MAX_RETRIES.
REQ-028 Outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-029 ResetN=0 SHALL force IDLE, all outputs 0, timers and RetryCount 0, and synchroniser flops 0, asynchronously.
REQ-030 Reset deassertion mid-operation SHALL resume from IDLE; Enable held high restarts the sequence from POWER_UP.

Configuration
REQ-031 Macro SPLIT_RADIO_STAGGER_EN defined: branch ramp per REQ-022.
REQ-032 SPLIT_RADIO_STAGGER_EN undefined: RAMP lasts one clock, sets all BranchEnable bits together, then READY; BRANCH_STEP is unused.

Structure
REQ-033 Package split_radio_pkg SHALL hold the state enum, the 3-bit state width and the default parameter constants.
REQ-034 Sub-module split_radio_pgood_sync SHALL implement the two-flop synchroniser with asynchronous active-low reset.

Verification
The bench uses SETTLE_CYCLES=8, BRANCH_STEP=4, PGOOD_TIMEOUT=32, MAX_RETRIES=3 and NUM_BRANCHES=4.
REQ-035 Nominal: Enable=1, ToSplitRadio=1 at clock 5 -> SETTLE by clock 7; BranchEnable 0001, 0011, 0111, 1111 at 4-clock spacing; Ready=1 one clock after 1111.
REQ-036 Timeout: Enable=1, ToSplitRadio=0 -> FAULT_WAIT after 32 clocks in POWER_UP; RetryCount=1; POWER_UP re-entered 8 clocks later.
REQ-037 Lockout: ToSplitRadio held 0 -> three timeouts -> LOCKOUT, Fault=1, RetryCount=3; Enable=0 -> IDLE, Fault=0, RetryCount=0.
REQ-038 Brownout: in READY drop ToSplitRadio for 1 clock -> within 3 clocks all enables 0, State=FAULT_WAIT, RetryCount=1.
REQ-039 Reset mid-RAMP with BranchEnable=0011: ResetN=0 -> all outputs 0 immediately; after release with Enable=1 -> POWER_UP next clock.
REQ-040 Build without SPLIT_RADIO_STAGGER_EN: BranchEnable 0000->1111 in one clock; Ready=1 the following clock.
